// File: rtl/mem_bus_pkg.sv
// mem_bus_pkg: cpustate encodings, responder FSM states and I/O port addresses
package mem_bus_pkg;
  localparam logic [1:0] CS_IDLE = 2'b00;
  localparam logic [1:0] CS_LOAD = 2'b01;
  localparam logic [1:0] CS_RUN = 2'b10;
  localparam logic [15:0] IO_IN_ADDR = 16'hFFFE;
  localparam logic [15:0] IO_OUT_ADDR = 16'hFFFF;
  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_RUN} state_t;
endpackage

// File: rtl/mem_bus_ram.sv
// mem_bus_ram: single-port synchronous RAM (clk, we, re, addr, wdata -> registered rdata)
module mem_bus_ram #(
  parameter int DEPTH = 256,
  parameter int AW = $clog2(DEPTH)
) (
  input logic clk,
  input logic we,
  input logic re,
  input logic [AW-1:0] addr,
  input logic [7:0] wdata,
  output logic [7:0] rdata
);
  logic [7:0] mem [DEPTH];
  always_ff @(posedge clk) begin
    if (we) mem[addr] <= wdata;
    if (re) rdata <= mem[addr];
  end
endmodule

// File: rtl/mem_bus_responder.sv
// mem_bus_responder: CPU bus RAM responder with switch loader; MEM_BUS_IOPORT_EN adds I/O ports at FFFE/FFFF
module mem_bus_responder
  import mem_bus_pkg::*;
#(
  parameter int MEM_DEPTH = 256
) (
  input logic clk,
  input logic rst,
  input logic [1:0] cpustate,
  input logic [15:0] addr,
  input logic [7:0] wdata,
  input logic read,
  input logic write,
  output logic [7:0] rdata,
  input logic [7:0] ld_data,
  input logic ld_strobe,
  output logic [15:0] ld_addr,
  input logic [7:0] in_port,
  output logic [7:0] out_port,
  output logic out_valid,
  output logic bus_err
);
  localparam int AW = $clog2(MEM_DEPTH);
  state_t state, state_n;
  logic [AW-1:0] ld_ptr, ram_addr;
  logic [7:0] ram_wdata, ram_q, alt_q;
  logic ram_we, ram_re, run_rd, run_wr, in_range, io_in, io_out, err_set, load_enter, src_ram;
`ifdef MEM_BUS_IOPORT_EN
  assign io_in = addr == IO_IN_ADDR;
  assign io_out = addr == IO_OUT_ADDR;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      out_port <= 8'h00;
      out_valid <= 1'b0;
    end else begin
      out_valid <= run_wr && io_out;
      if (run_wr && io_out) out_port <= wdata;
    end
`else
  logic unused_in;
  assign unused_in = ^in_port;
  assign io_in = 1'b0;
  assign io_out = 1'b0;
  assign out_port = 8'h00;
  assign out_valid = 1'b0;
`endif
  always_comb begin
    state_n = cpustate == CS_LOAD ? S_LOAD : cpustate == CS_RUN ? S_RUN : S_IDLE;
    load_enter = state_n == S_LOAD && state != S_LOAD;
    in_range = addr < 16'(MEM_DEPTH);
    run_wr = state == S_RUN && write;
    // a simultaneous write wins, so the read is dropped and rdata holds
    run_rd = state == S_RUN && read && !write;
    ram_we = state == S_LOAD ? ld_strobe : run_wr && in_range;
    ram_re = run_rd && in_range;
    ram_addr = state == S_LOAD ? ld_ptr : addr[AW-1:0];
    ram_wdata = state == S_LOAD ? ld_data : wdata;
    err_set = state == S_RUN && ((read && write) || (read && !(in_range || io_in || io_out)) ||
                                 (write && !(in_range || io_out)));
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state <= S_IDLE;
      ld_ptr <= '0;
      bus_err <= 1'b0;
      src_ram <= 1'b0;
      alt_q <= 8'h00;
    end else begin
      state <= state_n;
      if (load_enter) ld_ptr <= '0;
      else if (state == S_LOAD && ld_strobe) ld_ptr <= ld_ptr == AW'(MEM_DEPTH - 1) ? '0 : ld_ptr + 1'b1;
      bus_err <= load_enter ? 1'b0 : bus_err | err_set;
      // rdata comes from the RAM output register or from alt_q for I/O and out-of-range reads
      if (ram_re) src_ram <= 1'b1;
      else if (run_rd) begin
        src_ram <= 1'b0;
        alt_q <= io_in ? in_port : io_out ? out_port : 8'h00;
      end
    end
  assign rdata = src_ram ? ram_q : alt_q;
  assign ld_addr = 16'(ld_ptr);
  mem_bus_ram #(.DEPTH(MEM_DEPTH)) u_ram (
    .clk(clk),
    .we(ram_we),
    .re(ram_re),
    .addr(ram_addr),
    .wdata(ram_wdata),
    .rdata(ram_q)
  );
endmodule

// File: tb/tb_mem_bus_responder.sv
// tb_mem_bus_responder: scoreboard bench for mem_bus_responder
module tb_mem_bus_responder;
  import mem_bus_pkg::*;
`ifdef MEM_BUS_IOPORT_EN
  localparam bit IO = 1'b1;
`else
  localparam bit IO = 1'b0;
`endif
  localparam int RD = 0, LA = 1, OP = 2, OV = 3, BE = 4;
  logic clk = 1'b0, rst, read, write, ld_strobe, out_valid, bus_err;
  logic [1:0] cpustate;
  logic [15:0] addr, ld_addr;
  logic [7:0] wdata, rdata, ld_data, in_port, out_port;
  typedef struct {
    int due;
    int sig;
    logic [15:0] exp;
    string name;
  } chk_t;
  chk_t sb[$];
  int cyc = 0, checks = 0, errors = 0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  mem_bus_responder #(.MEM_DEPTH(256)) dut (
    .clk(clk), .rst(rst), .cpustate(cpustate), .addr(addr), .wdata(wdata),
    .read(read), .write(write), .rdata(rdata), .ld_data(ld_data),
    .ld_strobe(ld_strobe), .ld_addr(ld_addr), .in_port(in_port),
    .out_port(out_port), .out_valid(out_valid), .bus_err(bus_err)
  );
  function automatic logic [15:0] sig_val(input int s);
    return s == RD ? {8'h00, rdata} : s == LA ? ld_addr : s == OP ? {8'h00, out_port} :
           s == OV ? {15'd0, out_valid} : {15'd0, bus_err};
  endfunction
  always @(negedge clk) begin
    logic [15:0] act;
    for (int i = sb.size() - 1; i >= 0; i--)
      if (sb[i].due == cyc) begin
        act = sig_val(sb[i].sig);
        checks++;
        if (act !== sb[i].exp) begin
          errors++;
          $display("FAIL %s: got %h want %h (cycle %0d)", sb[i].name, act, sb[i].exp, cyc);
        end
        sb.delete(i);
      end
  end
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input int s, input logic [15:0] v, input int d, input string n);
    sb.push_back('{cyc + d, s, v, n});
  endtask
  task automatic chk_reset(input string n);
    chk(RD, 16'h00, 0, {n, "_rdata"});
    chk(LA, 16'h0000, 0, {n, "_ld_addr"});
    chk(OP, 16'h00, 0, {n, "_out_port"});
    chk(OV, 16'h0, 0, {n, "_out_valid"});
    chk(BE, 16'h0, 0, {n, "_bus_err"});
  endtask
  initial begin
    #100000;
    $display("FAIL watchdog: cycle %0d reached, bench did not finish", cyc);
    $fatal(1);
  end
  initial begin
    rst = 1'b1; cpustate = CS_IDLE; addr = '0; wdata = '0; read = 1'b0; write = 1'b0;
    ld_data = '0; ld_strobe = 1'b0; in_port = 8'h77;
    step;
    chk_reset("reset");
    step;
    rst = 1'b0;
    cpustate = CS_LOAD; step;
    ld_strobe = 1'b1; ld_data = 8'hA1; step;
    ld_data = 8'hB2; step;
    ld_data = 8'hC3; step;
    ld_strobe = 1'b0;
    chk(LA, 16'd3, 0, "load_ld_addr");
    cpustate = CS_RUN; step;
    read = 1'b1; addr = 16'h0000; chk(RD, 16'hA1, 1, "read0"); step;
    addr = 16'h0001; chk(RD, 16'hB2, 1, "read1"); step;
    addr = 16'h0002; chk(RD, 16'hC3, 1, "read2"); step;
    read = 1'b0; chk(RD, 16'hC3, 1, "rdata_hold"); step;
    write = 1'b1; addr = 16'h0010; wdata = 8'h5A; step;
    write = 1'b0; read = 1'b1; chk(RD, 16'h5A, 1, "write_readback"); chk(BE, 16'h0, 1, "no_err"); step;
    addr = 16'h0100; chk(RD, 16'h00, 1, "oor_read"); chk(BE, 16'h1, 1, "oor_err"); step;
    read = 1'b0; write = 1'b1; wdata = 8'hEE; step;
    write = 1'b0; read = 1'b1; addr = 16'h0000;
    chk(RD, 16'hA1, 1, "oor_write_dropped"); chk(BE, 16'h1, 1, "err_sticky"); step;
    read = 1'b0; cpustate = CS_IDLE; step;
    read = 1'b1; addr = 16'h0001; chk(RD, 16'hA1, 1, "idle_read_ignored"); step;
    read = 1'b0; write = 1'b1; addr = 16'h0002; wdata = 8'hFF; step;
    write = 1'b0; cpustate = CS_LOAD;
    chk(BE, 16'h0, 1, "load_clears_err"); chk(LA, 16'h0, 1, "load_entry_addr"); step;
    cpustate = CS_RUN; step;
    read = 1'b1; addr = 16'h0002; chk(RD, 16'hC3, 1, "idle_write_ignored"); step;
    read = 1'b0; write = 1'b1; addr = 16'hFFFF; wdata = 8'h3C;
    chk(OP, IO ? 16'h3C : 16'h00, 1, "io_out_port"); chk(OV, IO ? 16'h1 : 16'h0, 1, "io_out_valid");
    chk(BE, IO ? 16'h0 : 16'h1, 1, "io_err"); step;
    write = 1'b0; chk(OV, 16'h0, 1, "out_valid_pulse"); step;
    read = 1'b1; addr = 16'hFFFE; chk(RD, IO ? 16'h77 : 16'h00, 1, "io_in_read"); step;
    addr = 16'hFFFF; chk(RD, IO ? 16'h3C : 16'h00, 1, "io_out_read"); step;
    addr = 16'h0010; chk(RD, 16'h5A, 1, "pre_contention_read"); step;
    write = 1'b1; addr = 16'h0020; wdata = 8'h11;
    chk(RD, 16'h5A, 1, "contention_hold"); chk(BE, 16'h1, 1, "contention_err"); step;
    write = 1'b0; chk(RD, 16'h11, 1, "contention_write"); step;
    read = 1'b0; cpustate = CS_LOAD; step;
    ld_strobe = 1'b1;
    for (int i = 0; i < 257; i++) begin
      ld_data = i == 256 ? 8'hE7 : 8'(i + 1);
      step;
    end
    ld_strobe = 1'b0;
    chk(LA, 16'h0001, 0, "wrap_ld_addr");
    cpustate = CS_RUN; step;
    read = 1'b1; addr = 16'h0000; chk(RD, 16'hE7, 1, "wrap_ram0"); step;
    addr = 16'h0001; chk(RD, 16'h02, 1, "wrap_ram1"); step;
    addr = 16'h0080; chk(RD, 16'h81, 1, "wrap_ram80"); step;
    read = 1'b0; cpustate = CS_LOAD; step;
    ld_strobe = 1'b1; ld_data = 8'h9A; step;
    ld_data = 8'h9B; step;
    ld_strobe = 1'b0; chk(LA, 16'h0002, 0, "midload_ld_addr"); step;
    rst = 1'b1;
    chk_reset("async_reset");
    #1;
    checks++;
    if (rdata !== 8'h00) begin errors++; $display("FAIL async_now_rdata: got %h", rdata); end
    checks++;
    if (ld_addr !== 16'h0000) begin errors++; $display("FAIL async_now_ld_addr: got %h", ld_addr); end
    checks++;
    if (out_port !== 8'h00) begin errors++; $display("FAIL async_now_out_port: got %h", out_port); end
    checks++;
    if (out_valid !== 1'b0) begin errors++; $display("FAIL async_now_out_valid: got %b", out_valid); end
    checks++;
    if (bus_err !== 1'b0) begin errors++; $display("FAIL async_now_bus_err: got %b", bus_err); end
    step;
    rst = 1'b0; cpustate = CS_RUN; step;
    read = 1'b1; addr = 16'h0000; chk(RD, 16'h9A, 1, "kept_byte0"); step;
    addr = 16'h0001; chk(RD, 16'h9B, 1, "kept_byte1"); step;
    addr = 16'h0002; chk(RD, 16'h03, 1, "kept_byte2"); step;
    read = 1'b0; step; step;
    foreach (sb[i]) begin
      errors++;
      $display("FAIL %s: never checked (due cycle %0d)", sb[i].name, sb[i].due);
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/mem_bus_responder.md
# mem_bus_responder

Memory-side responder for the 8-bit CPU's external bus. It answers the CPU's `read`/`write` strobes on the 16-bit address and 8-bit data buses with a synchronous RAM array. It also provides a switch-driven program-load path, used while the CPU is in load state, and an optional memory-mapped I/O port pair. It sits beside `cpu` at board top level: `cpu.addr`/`data_out`/`read`/`write` come in, and `rdata` drives `cpu.data_in`.

## Interface
- `MEM_DEPTH`, 256: RAM words; power of two, at most 32768.
- `clk`  in  1  system clock; the same edge the CPU uses for its registers.
- `rst`  in  1  asynchronous, active-high reset.
- `cpustate`  in  2  mode: 2'b01 LOAD, 2'b10 RUN, 2'b00/2'b11 IDLE.
- `addr`  in  16  CPU address.
- `wdata`  in  8  CPU write data (`cpu.data_out`).
- `read`  in  1  CPU read strobe, sampled each cycle.
- `write`  in  1  CPU write strobe, sampled each cycle.
- `rdata`  out  8  read data to the CPU; held between reads.
- `ld_data`  in  8  loader byte from the switches.
- `ld_strobe`  in  1  one-cycle pulse from the debounced load button.
- `ld_addr`  out  16  next RAM address the loader will write.
- `in_port`  in  8  external input port.
- `out_port`  out  8  external output-port register.
- `out_valid`  out  1  one-cycle pulse when `out_port` is written.
- `bus_err`  out  1  sticky error flag.

## Operation
- FSM states: S_IDLE, S_LOAD, S_RUN. The state is the value of `cpustate` registered every cycle; any encoding change takes effect at the next edge.
- S_IDLE:
  - RAM and port registers are frozen.
  - `read` and `write` are ignored.
  - `rdata` holds its value.
- S_LOAD:
  - Entering from any other state sets `ld_addr` to 0 and clears `bus_err`.
  - Each `ld_strobe` writes `ld_data` to RAM[`ld_addr`] and increments `ld_addr`.
  - At `MEM_DEPTH-1`, `ld_addr` wraps to 0.
  - CPU strobes are ignored.
- S_RUN:
  - `ld_strobe` is ignored and `ld_addr` holds.
  - Read: `rdata` <= RAM[addr] if addr < `MEM_DEPTH`.
  - Write: RAM[addr] <= `wdata` if addr < `MEM_DEPTH`.
- I/O map (only when the macro below is defined):
  - 16'hFFFE read returns `in_port`, sampled at the read edge.
  - 16'hFFFF write loads `out_port` and pulses `out_valid`.
  - 16'hFFFF read returns `out_port`.
- Out-of-range access (addr >= `MEM_DEPTH` and not mapped I/O):
  - A read returns 8'h00.
  - A write is dropped.
  - `bus_err` is set.
- `read` and `write` in the same cycle: the write is performed, the read is discarded (`rdata` holds), and `bus_err` is set.
- `bus_err` is cleared only by `rst` or by entering S_LOAD.
- RAM contents are not reset.

## Timing
- Reset values:
  - state S_IDLE
  - `rdata` 8'h00
  - `ld_addr` 16'h0000
  - `out_port` 8'h00
  - `out_valid` 0
  - `bus_err` 0
- Read latency is 1 cycle. A read sampled at edge N updates `rdata` after edge N; the CPU asserts `membus` in the following state and captures the value at edge N+1.
- A write completes at the sampling edge. A read of the same address on the next cycle returns the new data.
- Mode changes take 1 cycle: a strobe coincident with a `cpustate` change is handled under the old registered state.
- `ld_strobe` high for k consecutive cycles writes k bytes; the source is responsible for pulse shaping.
- An `rst` assertion mid-load abandons the load; the RAM keeps the bytes already written.
- `out_valid` is high for exactly the cycle after the write edge.

## Configuration
- `MEM_BUS_IOPORT_EN` defined:
  - The 16'hFFFE/16'hFFFF I/O decode exists.
  - `out_port` and `out_valid` function as described.
- `MEM_BUS_IOPORT_EN` undefined:
  - Those addresses are treated as out-of-range.
  - `out_port` is tied to 8'h00 and `out_valid` to 0.
  - `in_port` is unused.

## Structure
- Shared package `mem_bus_pkg`:
  - `cpustate` encodings (CS_IDLE, CS_LOAD, CS_RUN)
  - FSM state typedef
  - `IO_IN_ADDR` = 16'hFFFE and `IO_OUT_ADDR` = 16'hFFFF
- Sub-module `mem_bus_ram`: single-port synchronous RAM with parameterized depth, write-enable, and registered read. It is shared by the load and run paths through a write-port mux. All decode and FSM logic stays in the top.

## Test plan
- Load sequence: `rst`; `cpustate`=LOAD; pulse `ld_strobe` with bytes 8'hA1, 8'hB2, 8'hC3 → `ld_addr`=3. Then `cpustate`=RUN and read addresses 0, 1, 2 → `rdata` 8'hA1, 8'hB2, 8'hC3, each one cycle after its read strobe.
- Run write/readback: write 8'h5A to 16'h0010, then read 16'h0010 on the next cycle → `rdata`=8'h5A; `bus_err` stays 0.
- Out of range (`MEM_DEPTH`=256): read 16'h0100 → `rdata`=8'h00 and `bus_err`=1. A following in-range read still works, and `bus_err` stays 1 until LOAD is entered.
- I/O with the macro defined: write 8'h3C to 16'hFFFF → `out_port`=8'h3C and a one-cycle `out_valid`. With `in_port`=8'h77, read 16'hFFFE → `rdata`=8'h77. Without the macro, the same write leaves `out_port`=8'h00 and sets `bus_err`.
- Contention and wrap:
  - `read` and `write` together on 16'h0020 with `wdata`=8'h11 → RAM[16'h0020]=8'h11, `rdata` unchanged, `bus_err`=1.
  - 257 load strobes → `ld_addr` wraps to 1, and RAM[0] holds the 257th byte.
- Async reset mid-load: assert `rst` between strobes → all outputs go to their reset values immediately; the bytes already written are still readable in RUN.
